prio_arb_rr: RTL and testbench
==============================

# prio_arb_rr

Parametrised, registered priority arbiter that generalises the 4-bit combinational priority encoder to N requesters. It selects between fixed-priority and round-robin modes and holds each grant until the owner releases it. It sits between N request sources and one shared resource. It produces a one-hot grant, the binary index of the owner, a valid flag, and a contention flag, all registered.

## Interface
- N, 8, number of requesters; legal range 2..32.
- IW, $clog2(N), derived index width; not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- en  in  1  arbitration enable; 0 blocks new grants but does not revoke an existing one.
- mode  in  1  0 = fixed priority, highest index wins; 1 = round-robin.
- req  in  N  request vector; a requester keeps its bit high for the whole duration of its use.
- grant  out  N  one-hot grant, or all zero.
- grant_idx  out  IW  index of the owner; 0 when valid=0.
- valid  out  1  high while any grant is held; equals |grant.
- multi  out  1  high while a grant is held if at least 2 req bits were set at the arbitration edge that issued it.

## Operation
- State machine IDLE / BUSY. Registers: state, grant, grant_idx, valid, multi, last (IW bits, index of the last winner).
- Reset, asynchronous and effective immediately: state=IDLE, grant=0, grant_idx=0, valid=0, multi=0, last=0.
- IDLE, with en=1 and |req=1: select winner w, then:
  - grant=1<<w, grant_idx=w, valid=1.
  - multi=(popcount(req)>=2), last=w.
  - Go to BUSY.
- IDLE, otherwise: stay; all outputs stay 0.
- BUSY, with req[grant_idx]=1: hold every output unchanged. Changes on other req bits, en or mode are ignored.
- BUSY, with req[grant_idx]=0 (release): re-arbitrate on the same edge over the current req.
  - If en=1 and |req=1, grant the new winner back-to-back with no idle cycle and stay in BUSY.
  - Otherwise clear all outputs and go to IDLE.
- Fixed mode (mode=0): w is the highest set index of req. Example with N=4: req=1100 gives w=3.
- Round-robin mode (mode=1): search downward starting at (last-1) mod N, wrapping from 0 to N-1. The first set bit wins. The previous winner therefore has the lowest priority.
  - After reset (last=0), the search starts at N-1, so the first round-robin pick equals the fixed-priority pick.
- last is updated on every grant in both modes. Switching modes takes effect only at the next arbitration edge.
- mode and en are sampled only at arbitration edges.
- Invariants:
  - grant is always 0 or one-hot.
  - grant_idx < N.
  - valid == |grant.
  - multi=1 implies valid=1.

## Timing
- Latency: request to grant is 1 cycle. req sampled at edge k gives grant visible after edge k.
- Release to handoff is 1 cycle. The owner drops req before edge k; after edge k the new grant or idle is visible.
- No combinational path from any input to any output.
- Boundary cases:
  - req going from all-zero to non-zero gives valid rising exactly one cycle later.
  - Owner releasing while no other request is pending gives valid=0 for at least one cycle.
  - Owner releasing and re-asserting between edges is invisible; the grant is held.
  - Reset asserted mid-grant clears all outputs asynchronously. After deassertion, arbitration restarts with last=0.
  - en low while BUSY: the grant is held until release, then the block goes to IDLE.

## Test plan
- Reset and zero input: rst=1, then req=0 for 5 cycles -> grant=0, grant_idx=0, valid=0, multi=0 on every cycle.
- Single-hot, fixed mode, N=4: drive req=0001, then 0010, 0100, 1000, releasing between each -> after each request, one cycle later: grant_idx=0,1,2,3 respectively, valid=1, multi=0.
- Fixed-priority contention, N=4: req=1100 -> grant=1000, grant_idx=3, multi=1. Then drop req[3] while keeping req[2] -> next cycle grant=0100, grant_idx=2, valid stays 1 (back-to-back), multi=0.
- Round-robin fairness, N=4, mode=1: hold req=1111 and have each owner release for one cycle after being granted -> grant_idx sequence 3,2,1,0,3.
- Hold and en: grant req[1]; raise req[3] and set en=0 -> grant stays 0010. Release req[1] with en=0 -> valid=0 next cycle. Set en=1 -> grant=1000 one cycle later.
- Asynchronous reset mid-grant: assert rst between clock edges while valid=1 -> all outputs 0 before the next edge. After release, req=0011 in mode=1 -> grant_idx=1.

Source files
------------

// File: rtl/prio_arb_rr_if.sv
// Request/grant bundle between N requesters and the shared-resource arbiter.
// The arbiter owns the grant side (slave); the requesters drive the request side (master).
interface prio_arb_rr_if #(
    parameter int N = 8
);
    localparam int IW = $clog2(N);

    logic          en;
    logic          mode;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          valid;
    logic          multi;

    modport master (
        output en, mode, req,
        input  grant, grant_idx, valid, multi
    );

    modport slave (
        input  en, mode, req,
        output grant, grant_idx, valid, multi
    );
endinterface

// File: rtl/prio_arb_rr.sv
// Registered N-way arbiter with fixed-priority or round-robin selection.
// A grant is held until its owner drops its request, then re-arbitrated on the same edge.
module prio_arb_rr #(
    parameter int N = 8
) (
    input logic         clk,
    input logic         rst,
    prio_arb_rr_if.slave bus
);
    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    logic [IW-1:0] last;

    logic [IW-1:0] rrStart;
    logic [IW-1:0] winIdx;
    logic [N-1:0]  winOneHot;
    logic          found;
    logic          anyReq;
    logic          multiReq;
    logic          arbitrate;

    // Winner selection: fixed mode takes the highest set bit; round-robin scans
    // downward from the slot below the previous winner, wrapping past zero.
    always_comb begin
        int j;
        j        = 0;
        found    = 1'b0;
        winIdx   = '0;
        rrStart  = (last == '0) ? IW'(N - 1) : last - 1'b1;
        anyReq   = |bus.req;
        multiReq = ($countones(bus.req) >= 2);
        if (!bus.mode) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) begin
                    winIdx = IW'(i);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                j = int'(rrStart) - k;
                if (j < 0) begin
                    j = j + N;
                end
                if (!found && bus.req[j]) begin
                    winIdx = IW'(j);
                    found  = 1'b1;
                end
            end
        end
        winOneHot         = '0;
        winOneHot[winIdx] = 1'b1;
        arbitrate         = (state == IDLE) || !bus.req[bus.grant_idx];
    end

    // While the owner keeps its request high nothing moves; otherwise this edge
    // either hands the resource to a new winner or returns to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.grant     <= '0;
            bus.grant_idx <= '0;
            bus.valid     <= 1'b0;
            bus.multi     <= 1'b0;
            last          <= '0;
        end else if (arbitrate) begin
            if (bus.en && anyReq) begin
                state         <= BUSY;
                bus.grant     <= winOneHot;
                bus.grant_idx <= winIdx;
                bus.valid     <= 1'b1;
                bus.multi     <= multiReq;
                last          <= winIdx;
            end else begin
                state         <= IDLE;
                bus.grant     <= '0;
                bus.grant_idx <= '0;
                bus.valid     <= 1'b0;
                bus.multi     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_prio_arb_rr.sv
// Directed self-checking bench for prio_arb_rr with four requesters.
module tb_prio_arb_rr;
    localparam int N = 4;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    prio_arb_rr_if #(.N(N)) bus ();

    prio_arb_rr #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of all outputs: {grant[3:0], grant_idx[1:0], valid, multi}
    function automatic logic [7:0] observed();
        return {bus.grant, bus.grant_idx, bus.valid, bus.multi};
    endfunction

    task automatic applyStimulus(input logic e, input logic m, input logic [N-1:0] r);
        bus.en   = e;
        bus.mode = m;
        bus.req  = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'b0000);
        #3;
        compared++;
        if (observed() !== 8'b0000_00_0_0) begin
            mismatched++;
            $display("[TB] FAIL reset_async: observed %b required %b", observed(), 8'b0);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            compared++;
            if (observed() !== 8'b0000_00_0_0) begin
                mismatched++;
                $display("[TB] FAIL reset_zero_req cycle %0d: observed %b required %b", c, observed(), 8'b0);
            end
        end
    endtask

    task automatic test_single_hot();
        logic [N-1:0] r;
        logic [7:0]   exp;
        for (int i = 0; i < N; i++) begin
            r = 4'b0001 << i;
            applyStimulus(1'b1, 1'b0, r);
            #1;
            compared++;
            if (bus.valid !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL single_hot_no_comb req %b: observed valid %b required 0", r, bus.valid);
            end
            tick();
            exp = {r, 2'(i), 1'b1, 1'b0};
            compared++;
            if (observed() !== exp) begin
                mismatched++;
                $display("[TB] FAIL single_hot req %b: observed %b required %b", r, observed(), exp);
            end
            applyStimulus(1'b1, 1'b0, 4'b0000);
            tick();
            compared++;
            if (observed() !== 8'b0) begin
                mismatched++;
                $display("[TB] FAIL single_hot_release req %b: observed %b required %b", r, observed(), 8'b0);
            end
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 1'b0, 4'b1100);
        tick();
        compared++;
        if (observed() !== 8'b1000_11_1_1) begin
            mismatched++;
            $display("[TB] FAIL fixed_contention: observed %b required %b", observed(), 8'b1000_11_1_1);
        end
        applyStimulus(1'b1, 1'b0, 4'b0100);
        tick();
        compared++;
        if (observed() !== 8'b0100_10_1_0) begin
            mismatched++;
            $display("[TB] FAIL back_to_back: observed %b required %b", observed(), 8'b0100_10_1_0);
        end
        applyStimulus(1'b1, 1'b0, 4'b0000);
        tick();
        compared++;
        if (observed() !== 8'b0) begin
            mismatched++;
            $display("[TB] FAIL release_to_idle: observed %b required %b", observed(), 8'b0);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] expIdx [5];
        logic [N-1:0] r;
        logic [N-1:0] g;
        expIdx = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        rst = 1'b1;
        #2;
        rst = 1'b0;
        r = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            applyStimulus(1'b1, 1'b1, r);
            tick();
            g = 4'b0001 << expIdx[s];
            compared++;
            if (observed() !== {g, expIdx[s], 1'b1, 1'b1}) begin
                mismatched++;
                $display("[TB] FAIL round_robin step %0d: observed %b required %b", s, observed(), {g, expIdx[s], 1'b1, 1'b1});
            end
            r = 4'b1111 & ~g;
        end
        applyStimulus(1'b1, 1'b1, 4'b0000);
        tick();
    endtask

    task automatic test_hold_en();
        applyStimulus(1'b1, 1'b0, 4'b0010);
        tick();
        compared++;
        if (observed() !== 8'b0010_01_1_0) begin
            mismatched++;
            $display("[TB] FAIL hold_grant: observed %b required %b", observed(), 8'b0010_01_1_0);
        end
        applyStimulus(1'b0, 1'b0, 4'b1010);
        tick();
        compared++;
        if (observed() !== 8'b0010_01_1_0) begin
            mismatched++;
            $display("[TB] FAIL hold_en_low: observed %b required %b", observed(), 8'b0010_01_1_0);
        end
        applyStimulus(1'b0, 1'b0, 4'b1000);
        tick();
        compared++;
        if (observed() !== 8'b0) begin
            mismatched++;
            $display("[TB] FAIL release_en_low: observed %b required %b", observed(), 8'b0);
        end
        applyStimulus(1'b1, 1'b0, 4'b1000);
        tick();
        compared++;
        if (observed() !== 8'b1000_11_1_0) begin
            mismatched++;
            $display("[TB] FAIL en_reraised: observed %b required %b", observed(), 8'b1000_11_1_0);
        end
        applyStimulus(1'b1, 1'b0, 4'b0000);
        tick();
    endtask

    task automatic test_async_reset();
        applyStimulus(1'b1, 1'b0, 4'b0011);
        tick();
        compared++;
        if (observed() !== 8'b0010_01_1_1) begin
            mismatched++;
            $display("[TB] FAIL pre_reset_grant: observed %b required %b", observed(), 8'b0010_01_1_1);
        end
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (observed() !== 8'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_mid_grant: observed %b required %b", observed(), 8'b0);
        end
        tick();
        #2;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'b0011);
        tick();
        compared++;
        if (observed() !== 8'b0010_01_1_1) begin
            mismatched++;
            $display("[TB] FAIL rr_after_reset: observed %b required %b", observed(), 8'b0010_01_1_1);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'b0000);
        test_reset();
        test_single_hot();
        test_back_to_back();
        test_round_robin();
        test_hold_en();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
